// File: rtl/plic_timer_bank.sv
// Bank of N_CH interval timers feeding PLIC interrupt sources.
// Each channel: prescaler, up-counter with >= reload compare, sticky EXP/OVR, level or pulse irq.
//
// state    | meaning
// IDLE     | RUN=0; cnt and psc held at 0, no expiry
// COUNTING | RUN=1; psc paces ticks, cnt climbs to RELOAD then expires
module plic_timer_bank #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int AW    = $clog2(N_CH) + 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            reg_we_i,
    input  logic            reg_re_i,
    input  logic [AW-1:0]   reg_addr_i,
    input  logic [31:0]     reg_wdata_i,
    output logic [31:0]     reg_rdata_o,
    output logic            reg_rvalid_o,
    input  logic [N_CH-1:0] irq_ack_i,
    output logic [N_CH-1:0] irq_o
);

    localparam int CH_W = (AW > 2) ? AW - 2 : 1;

    typedef enum logic {IDLE = 1'b0, COUNTING = 1'b1} state_t;

    logic [CH_W-1:0] ch_idx;
    logic [1:0]      sel;

    state_t          state_q  [N_CH];
    state_t          state_d  [N_CH];
    logic [7:0]      presc_q  [N_CH];
    logic [7:0]      presc_d  [N_CH];
    logic [7:0]      psc_q    [N_CH];
    logic [7:0]      psc_d    [N_CH];
    logic [CNT_W-1:0] reload_q [N_CH];
    logic [CNT_W-1:0] reload_d [N_CH];
    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] cnt_d    [N_CH];

    logic [N_CH-1:0] en_q, en_d, edge_q, edge_d, oneshot_q, oneshot_d;
    logic [N_CH-1:0] exp_q, exp_d, ovr_q, ovr_d, expire_q, irq_q, irq_d;
    logic [N_CH-1:0] wr_ctrl, wr_reload, wr_status, tick, sw_stop, expire, exp_clr, ovr_clr;
    logic [31:0]     rd_word;

    // Write-data bits outside every register field are simply dropped.
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata_i;

    if (AW > 2) begin : g_ch_idx
        assign ch_idx = reg_addr_i[AW-1:2];
    end else begin : g_ch_idx_single
        assign ch_idx = 1'b0;
    end

    assign sel   = reg_addr_i[1:0];
    assign irq_o = irq_q;

    always_comb begin
        wr_ctrl   = '0;
        wr_reload = '0;
        wr_status = '0;
        tick      = '0;
        sw_stop   = '0;
        expire    = '0;
        exp_clr   = '0;
        ovr_clr   = '0;
        en_d      = en_q;
        edge_d    = edge_q;
        oneshot_d = oneshot_q;
        exp_d     = exp_q;
        ovr_d     = ovr_q;
        irq_d     = '0;
        rd_word   = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            presc_d[i]  = presc_q[i];
            psc_d[i]    = psc_q[i];
            reload_d[i] = reload_q[i];
            cnt_d[i]    = cnt_q[i];

            if (reg_we_i && (ch_idx == CH_W'(i))) begin
                wr_ctrl[i]   = (sel == 2'd0);
                wr_reload[i] = (sel == 2'd1);
                wr_status[i] = (sel == 2'd2);
            end

            tick[i]    = (state_q[i] == COUNTING) && (psc_q[i] == presc_q[i]);
            // Software clearing RUN beats an expiry landing in the same cycle.
            sw_stop[i] = wr_ctrl[i] && !reg_wdata_i[2];
            expire[i]  = tick[i] && (cnt_q[i] >= reload_q[i]) && !sw_stop[i];

            if (wr_ctrl[i]) begin
                state_d[i]   = reg_wdata_i[2] ? COUNTING : IDLE;
                en_d[i]      = reg_wdata_i[0];
                edge_d[i]    = reg_wdata_i[1];
                oneshot_d[i] = reg_wdata_i[3];
                presc_d[i]   = reg_wdata_i[15:8];
            end else if (expire[i] && oneshot_q[i]) begin
                state_d[i] = IDLE;
            end

            if (wr_reload[i]) begin
                reload_d[i] = reg_wdata_i[CNT_W-1:0];
            end

            if ((state_q[i] == IDLE) || sw_stop[i]) begin
                cnt_d[i] = '0;
                psc_d[i] = '0;
            end else if (tick[i]) begin
                psc_d[i] = '0;
                cnt_d[i] = (cnt_q[i] >= reload_q[i]) ? '0 : cnt_q[i] + CNT_W'(1);
            end else begin
                psc_d[i] = psc_q[i] + 8'd1;
            end

            exp_clr[i] = (wr_status[i] && reg_wdata_i[0]) || irq_ack_i[i];
            ovr_clr[i] = wr_status[i] && reg_wdata_i[1];
            if (expire[i]) begin
                exp_d[i] = 1'b1;
            end else if (exp_clr[i]) begin
                exp_d[i] = 1'b0;
            end
            if (expire[i] && exp_q[i] && !exp_clr[i]) begin
                ovr_d[i] = 1'b1;
            end else if (ovr_clr[i]) begin
                ovr_d[i] = 1'b0;
            end

            irq_d[i] = en_q[i] && (edge_q[i] ? expire_q[i] : exp_q[i]);

            if (ch_idx == CH_W'(i)) begin
                case (sel)
                    2'd0: rd_word = {16'h0, presc_q[i], 4'h0, oneshot_q[i],
                                     state_q[i] == COUNTING, edge_q[i], en_q[i]};
                    2'd1: rd_word = 32'(reload_q[i]);
                    2'd2: rd_word = {30'h0, ovr_q[i], exp_q[i]};
                    default: rd_word = 32'(cnt_q[i]);
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= IDLE;
                presc_q[i]  <= '0;
                psc_q[i]    <= '0;
                reload_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            en_q         <= '0;
            edge_q       <= '0;
            oneshot_q    <= '0;
            exp_q        <= '0;
            ovr_q        <= '0;
            expire_q     <= '0;
            irq_q        <= '0;
            reg_rdata_o  <= '0;
            reg_rvalid_o <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                presc_q[i]  <= presc_d[i];
                psc_q[i]    <= psc_d[i];
                reload_q[i] <= reload_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            en_q         <= en_d;
            edge_q       <= edge_d;
            oneshot_q    <= oneshot_d;
            exp_q        <= exp_d;
            ovr_q        <= ovr_d;
            expire_q     <= expire;
            irq_q        <= irq_d;
            reg_rvalid_o <= reg_re_i;
            if (reg_re_i) begin
                reg_rdata_o <= rd_word;
            end
        end
    end

endmodule

// File: doc/plic_timer_bank.md
Name: plic_timer_bank

Overview:
Parametrised bank of N_CH independent interval timers. Each channel generates one interrupt source for the PLIC gateway through irq_o[ch]. Each channel has its own prescaler, reload value, one-shot or periodic mode, level or edge output mode, sticky status and overrun flag. Configuration uses a simple word-addressed register port, and the block sits beside plic_top, driving selected irq_sources_i bits.

Parameters:
N_CH, 4, number of timer channels (1..16)
CNT_W, 32, counter and reload width (8..32)
AW, $clog2(N_CH)+2, register address width (derived; do not override)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset: one clock; reset is synchronous and active-high
reg_we_i  input  1  register write strobe
reg_re_i  input  1  register read strobe
reg_addr_i  input  AW  {channel[AW-3:0], sel[1:0]}
reg_wdata_i  input  32  write data
reg_rdata_o  output  32  read data, valid with reg_rvalid_o
reg_rvalid_o  output  1  read data valid, one cycle after reg_re_i
irq_ack_i  input  N_CH  per-channel status clear, e.g. PLIC complete
irq_o  output  N_CH  interrupt to PLIC source inputs

Behaviour:
Register map per channel (sel):
- 0 CTRL (RW):
  - [0] EN: output gate.
  - [1] EDGE: 1 = one-cycle pulse, 0 = level.
  - [2] RUN.
  - [3] ONESHOT.
  - [15:8] PRESC.
  - Other bits read 0.
- 1 RELOAD (RW): [CNT_W-1:0]; upper bits read 0.
- 2 STATUS (R/W1C): [0] EXP, [1] OVR.
- 3 COUNT (RO): current counter; writes ignored.
- Channel index >= N_CH: writes ignored, reads return 0.

Reset (rst_i sampled high at a clock edge):
- All CTRL, RELOAD, COUNT, STATUS and prescaler counters go to 0.
- irq_o = 0, reg_rvalid_o = 0, reg_rdata_o = 0.
- Reset mid-count aborts the count with no expiry.

Reads:
- reg_rdata_o is registered and appears on the cycle after reg_re_i, with reg_rvalid_o high for exactly one cycle.
- reg_rdata_o holds its last value otherwise.
- Read has no side effects.
- Simultaneous we and re to the same address: read returns the pre-write value.

Prescaler:
- Per-channel psc counter. While RUN=1, tick = (psc == PRESC).
- On tick psc goes to 0, otherwise psc increments.
- PRESC = 0 gives a tick every cycle.

Counter, per channel (states IDLE, COUNTING):
- IDLE (RUN=0): cnt = 0, psc = 0, no expiry.
- IDLE -> COUNTING on RUN set. The first tick occurs PRESC+1 cycles after the write.
- COUNTING on tick:
  - If cnt >= RELOAD: cnt goes to 0 and an expire event fires.
  - Else cnt increments.
  - The >= comparison means that lowering RELOAD below cnt expires on the next tick. cnt never wraps through 2^CNT_W.
- RELOAD writes take effect immediately, with no shadow register.
- ONESHOT=1: on expire, hardware clears RUN, returning to IDLE in the same cycle. A software write of CTRL in that same cycle wins.
- Clearing RUN during COUNTING: cnt and psc go to 0 on the next edge and any expiry in that cycle is suppressed.
- Period = (RELOAD+1)*(PRESC+1) cycles. RELOAD=0 with PRESC=0 expires every cycle.

Status:
- Expire sets EXP. If EXP was already 1, it also sets OVR.
- EXP is cleared by a W1C write of bit0 or by irq_ack_i[ch]. OVR is cleared only by a W1C write of bit1.
- Set and clear in the same cycle: set wins, and OVR is not set by that event.

Output:
- Level mode (EDGE=0): irq_o[ch] = EN & EXP, registered, asserted the cycle after expire.
- Edge mode (EDGE=1): irq_o[ch] = EN & expire, delayed one cycle and high for exactly one cycle per expire. EXP/OVR still update.
- EN=0 masks the output only; counting and status continue.
- Changing EDGE while EXP=1 and EN=1 switches the output to the new mode on the next cycle.

Test Plan:
1. Reset, then ch0 RELOAD=4, CTRL=0x05 (EN, RUN, level, PRESC=0) -> irq_o[0] rises 6 cycles after the CTRL write. COUNT reads 0..4 repeating. irq_o stays high until irq_ack_i[0]; a second expire before ack sets OVR (STATUS reads 0x3).
2. ch1 RELOAD=2, CTRL = EN|EDGE|RUN|PRESC=3 (0x0307) -> irq_o[1] high exactly one cycle, every 12 cycles. STATUS.EXP is set after the first pulse.
3. ch2 ONESHOT: RELOAD=3, CTRL=0x0D -> exactly one expire. CTRL reads 0x09 afterwards, COUNT reads 0, and there are no further irq pulses over 50 cycles.
4. ch0 counting with RELOAD=100. When COUNT reaches 50, write RELOAD=10 -> expire on the next tick, and COUNT reads 0 the following cycle.
5. EXP set by expire in the same cycle as a W1C write to STATUS -> EXP reads 1 and OVR reads 0. Read of address ch=N_CH (when N_CH<2^(AW-2)) -> rdata 0, rvalid after 1 cycle.
6. Assert rst_i mid-count on all channels -> the next cycle shows irq_o=0 and all registers 0. Deassert -> no irq for 200 cycles.
